// File: rtl/vote_round_ctrl.sv
// ============================================================================
// vote_round_ctrl : ballot-round sequencer for 4-voter majority/unanimous/tie
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module vote_round_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  input  logic       result_ack,
  output logic       busy,
  output logic [3:0] voted,
  output logic       result_valid,
  output logic       maj,
  output logic       uni,
  output logic       tie,
  output logic       timed_out,
  output logic [7:0] round_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EVAL    = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       voted_q, voted_d;
  logic [3:0]       votes_q, votes_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timed_out_q, timed_out_d;
  logic             result_valid_q, result_valid_d;
  logic             maj_q, maj_d;
  logic             uni_q, uni_d;
  logic             tie_q, tie_d;
  logic [7:0]       round_cnt_q, round_cnt_d;

  logic [3:0] w_vote_new;
  logic [3:0] w_voted_all;
  logic [2:0] w_ones;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
  endfunction

  // First vote wins: only voters not yet latched this round may update.
  assign w_vote_new  = vote_valid & ~voted_q;
  assign w_voted_all = voted_q | vote_valid;
  assign w_ones      = popcnt4(votes_q);

  always_comb begin
    state_d        = state_q;
    voted_d        = voted_q;
    votes_d        = votes_q;
    timer_d        = timer_q;
    timed_out_d    = timed_out_q;
    result_valid_d = result_valid_q;
    maj_d          = maj_q;
    uni_d          = uni_q;
    tie_d          = tie_q;
    round_cnt_d    = round_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COLLECT;
          voted_d     = 4'h0;
          votes_d     = 4'h0;
          timer_d     = '0;
          timed_out_d = 1'b0;
          maj_d       = 1'b0;
          uni_d       = 1'b0;
          tie_d       = 1'b0;
        end
      end

      ST_COLLECT: begin
        votes_d = (votes_q & ~w_vote_new) | (vote_val & w_vote_new);
        voted_d = w_voted_all;
        if (w_voted_all == 4'hF) begin
          state_d = ST_EVAL;
        end else if (timer_q == C_TMR_LAST) begin
          state_d     = ST_EVAL;
          timed_out_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_EVAL: begin
        maj_d       = (w_ones >= 3'd3);
        uni_d       = (w_ones == 3'd0) || (w_ones == 3'd4);
        tie_d       = (w_ones == 3'd2);
        round_cnt_d = round_cnt_q + 8'd1;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        // Valid trails the flags by one cycle so the consumer never sees them settle.
        if (!result_valid_q) begin
          result_valid_d = 1'b1;
        end else if (result_ack) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      voted_q        <= 4'h0;
      votes_q        <= 4'h0;
      timer_q        <= '0;
      timed_out_q    <= 1'b0;
      result_valid_q <= 1'b0;
      maj_q          <= 1'b0;
      uni_q          <= 1'b0;
      tie_q          <= 1'b0;
      round_cnt_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      voted_q        <= voted_d;
      votes_q        <= votes_d;
      timer_q        <= timer_d;
      timed_out_q    <= timed_out_d;
      result_valid_q <= result_valid_d;
      maj_q          <= maj_d;
      uni_q          <= uni_d;
      tie_q          <= tie_d;
      round_cnt_q    <= round_cnt_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign voted        = voted_q;
  assign result_valid = result_valid_q;
  assign maj          = maj_q;
  assign uni          = uni_q;
  assign tie          = tie_q;
  assign timed_out    = timed_out_q;
  assign round_cnt    = round_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vote_round_ctrl.sv
// ============================================================================
// tb_vote_round_ctrl : directed bench with a round-level reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_vote_round_ctrl;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int TMR_W          = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic       result_ack;
  logic       busy;
  logic [3:0] voted;
  logic       result_valid;
  logic       maj;
  logic       uni;
  logic       tie;
  logic       timed_out;
  logic [7:0] round_cnt;

  int n_vec = 0;
  int n_bad = 0;

  vote_round_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vote_valid  (vote_valid),
    .vote_val    (vote_val),
    .result_ack  (result_ack),
    .busy        (busy),
    .voted       (voted),
    .result_valid(result_valid),
    .maj         (maj),
    .uni         (uni),
    .tie         (tie),
    .timed_out   (timed_out),
    .round_cnt   (round_cnt)
  );

  always #5 clk = ~clk;

  // Round-level reference: a round is open, collecting for up to TIMEOUT_CYCLES
  // edges, then the result appears two edges after the round closes.
  logic       m_busy = 1'b0;
  logic       m_coll = 1'b0;
  logic [3:0] m_voted = 4'h0;
  logic [3:0] m_votes = 4'h0;
  int         m_age = 0;
  int         m_wait = 0;
  logic       m_rv = 1'b0;
  logic       m_maj = 1'b0;
  logic       m_uni = 1'b0;
  logic       m_tie = 1'b0;
  logic       m_to = 1'b0;
  int         m_cnt = 0;

  task automatic model_step();
    int n;
    if (!rst_n) begin
      m_busy = 0; m_coll = 0; m_voted = 0; m_votes = 0; m_age = 0; m_wait = 0;
      m_rv = 0; m_maj = 0; m_uni = 0; m_tie = 0; m_to = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_coll = 1; m_voted = 0; m_votes = 0; m_age = 0;
        m_to = 0; m_maj = 0; m_uni = 0; m_tie = 0;
      end
    end else if (m_coll) begin
      for (int i = 0; i < 4; i++) begin
        if (vote_valid[i] && !m_voted[i]) begin
          m_votes[i] = vote_val[i];
          m_voted[i] = 1'b1;
        end
      end
      m_age++;
      if (m_voted == 4'hF) begin
        m_coll = 0; m_wait = 2;
      end else if (m_age == TIMEOUT_CYCLES) begin
        m_coll = 0; m_to = 1; m_wait = 2;
      end
    end else if (!m_rv) begin
      m_wait--;
      if (m_wait == 0) begin
        n = $countones(m_votes);
        m_maj = (n >= 3);
        m_uni = (n == 0) || (n == 4);
        m_tie = (n == 2);
        m_rv  = 1;
        m_cnt = (m_cnt + 1) % 256;
      end
    end else if (result_ack) begin
      m_busy = 0; m_rv = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags and the counter are only compared once the model has settled a round.
  initial forever begin
    @(negedge clk);
    chk("m_busy", {7'b0, busy}, {7'b0, m_busy});
    chk("m_voted", {4'b0, voted}, {4'b0, m_voted});
    chk("m_rv", {7'b0, result_valid}, {7'b0, m_rv});
    if (m_wait == 0 || m_rv) begin
      chk("m_flags", {4'b0, maj, uni, tie, timed_out}, {4'b0, m_maj, m_uni, m_tie, m_to});
      chk("m_cnt", round_cnt, m_cnt[7:0]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rv(input int max_cyc, output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (result_valid !== 1'b1) chk("rv_timeout", {7'b0, result_valid}, 8'd1);
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b1; vote_valid = 4'h5; vote_val = 4'hA; result_ack = 1'b0;
    tick();
    vote_valid = ~vote_valid; vote_val = ~vote_val;
    tick();
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_rv", {7'b0, result_valid}, 8'd0);
    chk("rst_voted", {4'b0, voted}, 8'd0);
    chk("rst_flags", {4'b0, maj, uni, tie, timed_out}, 8'd0);
    chk("rst_cnt", round_cnt, 8'd0);
    rst_n = 1'b1; start = 1'b0; vote_valid = 4'h0; vote_val = 4'h0;
    tick();

    // Full round, minimum latency
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'hF; vote_val = 4'hE;
    tick();
    vote_valid = 4'h0;
    tick();
    chk("full_rv_early", {7'b0, result_valid}, 8'd0);
    tick();
    chk("full_rv", {7'b0, result_valid}, 8'd1);
    chk("full_flags", {4'b0, maj, uni, tie, timed_out}, 8'b1000);
    chk("full_cnt", round_cnt, 8'd1);
    do_ack();
    chk("full_idle", {7'b0, busy}, 8'd0);

    // Staggered votes with an ignored repeat from A
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_valid = 4'h8; vote_val = 4'h8; tick();
    vote_valid = 4'h4; vote_val = 4'h4; tick();
    vote_valid = 4'h8; vote_val = 4'h0; tick();
    vote_valid = 4'h2; vote_val = 4'h0; tick();
    vote_valid = 4'h1; vote_val = 4'h0; tick();
    vote_valid = 4'h0;
    wait_rv(8, n);
    chk("stag_flags", {4'b0, maj, uni, tie, timed_out}, 8'b0010);
    chk("stag_voted", {4'b0, voted}, 8'h0F);
    do_ack();

    // Timeout with only A and B voting
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'hC; vote_val = 4'hC;
    tick();
    vote_valid = 4'h0;
    wait_rv(40, n);
    chk("tmo_latency", n[7:0], 8'd17);
    chk("tmo_flags", {4'b0, maj, uni, tie, timed_out}, 8'b0011);
    chk("tmo_voted", {4'b0, voted}, 8'h0C);

    // Hold without ack; start must be ignored
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rv", {7'b0, result_valid}, 8'd1);
      chk("hold_cnt", round_cnt, 8'd3);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0; start = 1'b0;
    chk("ackstart_busy", {7'b0, busy}, 8'd0);
    chk("ackstart_rv", {7'b0, result_valid}, 8'd0);
    tick();
    chk("ackstart_idle", {7'b0, busy}, 8'd0);
    chk("idle_keep_to", {7'b0, timed_out}, 8'd1);

    // Abort mid-collect clears everything
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'h8; vote_val = 4'h8;
    tick();
    vote_valid = 4'h0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", {7'b0, busy}, 8'd0);
    chk("abort_cnt", round_cnt, 8'd0);
    chk("abort_voted", {4'b0, voted}, 8'd0);
    tick();

    // 256 rounds wrap the counter, sweeping every vote pattern
    for (int i = 0; i < 256; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0; vote_valid = 4'hF; vote_val = 4'(i);
      tick();
      vote_valid = 4'h0;
      wait_rv(8, n);
      if (i == 0) begin
        chk("wrap_first_cnt", round_cnt, 8'd1);
        chk("pc0_flags", {4'b0, maj, uni, tie, timed_out}, 8'b0100);
      end
      if (i == 8) chk("pc1_flags", {4'b0, maj, uni, tie, timed_out}, 8'b0000);
      do_ack();
    end
    chk("wrap_cnt", round_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
